mpt_tlb: RTL and testbench

- Permission cache between the MPT checker front-end and the MPT page-table walker (PTW).
- Each entry holds the MPT permission for one 4 KiB physical page, tagged by physical page number and SDID.
- On a hit the block answers the requester directly.
- On a miss it issues one walk to the PTW, refills from the walk result, then answers.

---
 rtl/mpt_tlb.sv | 195 +++++++++++++++++++
 tb/tb_mpt_tlb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mpt_tlb.sv
// MPT permission cache: fully-associative entries tagged by physical page number and SDID.
// Misses issue one walk to the PTW and refill from the result before answering.
module mpt_tlb #(
  parameter int TLB_ENTRIES = 8,
  parameter int PLEN        = 56,
  parameter int SDID_LEN    = 6,
  parameter int CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [PLEN-1:0]     req_paddr_i,
  input  logic [SDID_LEN-1:0] req_sdid_i,
  input  logic [1:0]          req_access_i,
  output logic                resp_valid_o,
  output logic                resp_allow_o,
  output logic                resp_fault_o,
  output logic                ptw_req_valid_o,
  input  logic                ptw_req_ready_i,
  output logic [PLEN-1:0]     ptw_req_paddr_o,
  output logic [SDID_LEN-1:0] ptw_req_sdid_o,
  input  logic                ptw_resp_valid_i,
  input  logic [1:0]          ptw_resp_perm_i,
  input  logic                ptw_resp_error_i,
  output logic [CNT_W-1:0]    hit_cnt_o,
  output logic [CNT_W-1:0]    miss_cnt_o
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);
  localparam int PPN_W = PLEN - 12;

  typedef enum logic [2:0] {IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESPOND} state_t;

  state_t state, state_next;

  logic [PLEN-1:0]     paddr_q;
  logic [SDID_LEN-1:0] sdid_q;
  logic [1:0]          access_q;
  logic [1:0]          perm_q;
  logic                error_q;
  logic                nofill_q;

  logic [TLB_ENTRIES-1:0] valid;
  logic [PPN_W-1:0]       entry_ppn  [TLB_ENTRIES];
  logic [SDID_LEN-1:0]    entry_sdid [TLB_ENTRIES];
  logic [1:0]             entry_perm [TLB_ENTRIES];
  logic [IDX_W-1:0]       ptr;

  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  logic             hit;
  logic [1:0]       hit_perm;
  logic             free_found;
  logic [IDX_W-1:0] victim;
  logic             accept;
  logic             refill;

  function automatic logic perm_ok(input logic [1:0] perm, input logic [1:0] access);
    case (access)
      2'b01:   perm_ok = (perm != 2'b00);
      2'b10:   perm_ok = perm[1];
      2'b11:   perm_ok = perm[0];
      default: perm_ok = 1'b0;
    endcase
  endfunction

  assign req_ready_o = (state == IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign refill      = (state == WALK_WAIT) && ptw_resp_valid_i && !ptw_resp_error_i &&
                       !nofill_q && !flush_i;

  always_comb begin
    hit      = 1'b0;
    hit_perm = 2'b00;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (valid[i] && entry_ppn[i] == paddr_q[PLEN-1:12] && entry_sdid[i] == sdid_q) begin
        hit      = 1'b1;
        hit_perm = entry_perm[i];
      end
    end
  end

  // Descending scan so the lowest-index free slot is the one that sticks.
  always_comb begin
    free_found = 1'b0;
    victim     = ptr;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        victim     = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next      = state;
    resp_valid_o    = 1'b0;
    resp_allow_o    = 1'b0;
    resp_fault_o    = 1'b0;
    ptw_req_valid_o = 1'b0;
    ptw_req_paddr_o = '0;
    ptw_req_sdid_o  = '0;
    case (state)
      IDLE: if (accept) state_next = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          resp_valid_o = 1'b1;
          resp_allow_o = perm_ok(hit_perm, access_q);
          state_next   = IDLE;
        end else begin
          state_next = WALK_REQ;
        end
      end
      WALK_REQ: begin
        ptw_req_valid_o = 1'b1;
        ptw_req_paddr_o = paddr_q;
        ptw_req_sdid_o  = sdid_q;
        if (ptw_req_ready_i) state_next = WALK_WAIT;
      end
      WALK_WAIT: if (ptw_resp_valid_i) state_next = RESPOND;
      RESPOND: begin
        resp_valid_o = 1'b1;
        resp_fault_o = error_q;
        resp_allow_o = !error_q && perm_ok(perm_q, access_q);
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A flush seen anywhere in the walk window suppresses the refill of that walk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_q  <= '0;
      sdid_q   <= '0;
      access_q <= 2'b00;
      perm_q   <= 2'b00;
      error_q  <= 1'b0;
      nofill_q <= 1'b0;
    end else begin
      if (accept) begin
        paddr_q  <= req_paddr_i;
        sdid_q   <= req_sdid_i;
        access_q <= req_access_i;
        nofill_q <= 1'b0;
      end else if ((state == WALK_REQ || state == WALK_WAIT) && flush_i) begin
        nofill_q <= 1'b1;
      end
      if (state == WALK_WAIT && ptw_resp_valid_i) begin
        perm_q  <= ptw_resp_perm_i;
        error_q <= ptw_resp_error_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid <= '0;
      ptr   <= '0;
    end else begin
      if (flush_i)     valid         <= '0;
      else if (refill) valid[victim] <= 1'b1;
      if (refill && !free_found) ptr <= ptr + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (refill) begin
      entry_ppn[victim]  <= paddr_q[PLEN-1:12];
      entry_sdid[victim] <= sdid_q;
      entry_perm[victim] <= ptw_resp_perm_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_cnt != '1)        hit_cnt  <= hit_cnt + CNT_W'(1);
      else if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;

endmodule

// File: tb/tb_mpt_tlb.sv
// Directed self-checking bench for mpt_tlb; the bench plays the PTW and
// predicts latency, allow/fault, walk counts and the hit/miss counters.
module tb_mpt_tlb;

  localparam int PLEN     = 56;
  localparam int SDID_LEN = 6;
  localparam int CNT_W    = 32;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                flush_i = 1'b0;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic [PLEN-1:0]     req_paddr_i = '0;
  logic [SDID_LEN-1:0] req_sdid_i = '0;
  logic [1:0]          req_access_i = 2'b00;
  logic                resp_valid_o;
  logic                resp_allow_o;
  logic                resp_fault_o;
  logic                ptw_req_valid_o;
  logic                ptw_req_ready_i = 1'b0;
  logic [PLEN-1:0]     ptw_req_paddr_o;
  logic [SDID_LEN-1:0] ptw_req_sdid_o;
  logic                ptw_resp_valid_i = 1'b0;
  logic [1:0]          ptw_resp_perm_i = 2'b00;
  logic                ptw_resp_error_i = 1'b0;
  logic [CNT_W-1:0]    hit_cnt_o;
  logic [CNT_W-1:0]    miss_cnt_o;

  int num_checks = 0;
  int num_passed = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  mpt_tlb #(.TLB_ENTRIES(8), .PLEN(PLEN), .SDID_LEN(SDID_LEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr_i),
    .req_sdid_i(req_sdid_i), .req_access_i(req_access_i),
    .resp_valid_o(resp_valid_o), .resp_allow_o(resp_allow_o), .resp_fault_o(resp_fault_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_req_paddr_o(ptw_req_paddr_o), .ptw_req_sdid_o(ptw_req_sdid_o),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_perm_i(ptw_resp_perm_i),
    .ptw_resp_error_i(ptw_resp_error_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed === expected) num_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One request from acceptance to response; the bench answers walks after 'delay' stall cycles
  // and pulses flush_i on cycle 'flush_cycle' after acceptance (0 = never).
  task automatic applyStimulus(input logic [PLEN-1:0] addr, input logic [SDID_LEN-1:0] sd,
                               input logic [1:0] acc, input logic [1:0] perm, input logic err,
                               input int delay, input int flush_cycle,
                               output logic allow, output logic fault, output int walks,
                               output logic [PLEN-1:0] waddr, output int lat, output logic stable);
    logic done = 1'b0;
    logic hs = 1'b0;
    logic seen = 1'b0;
    int waited = 0;
    allow = 1'b0; fault = 1'b0; walks = 0; waddr = '0; lat = 0; stable = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_paddr_i = addr; req_sdid_i = sd; req_access_i = acc;
    checkOutput("req_ready", {63'd0, req_ready_o}, 64'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      ptw_resp_valid_i = 1'b0;
      ptw_req_ready_i  = 1'b0;
      flush_i          = (c == flush_cycle);
      if (resp_valid_o) begin
        done = 1'b1; allow = resp_allow_o; fault = resp_fault_o; lat = c;
      end else if (hs) begin
        ptw_resp_valid_i = 1'b1; ptw_resp_perm_i = perm; ptw_resp_error_i = err; hs = 1'b0;
      end else if (ptw_req_valid_o) begin
        if (!seen) waddr = ptw_req_paddr_o;
        else if (ptw_req_paddr_o !== waddr) stable = 1'b0;
        seen = 1'b1;
        if (waited >= delay) begin ptw_req_ready_i = 1'b1; hs = 1'b1; walks++; end
        else waited++;
      end
      @(negedge clk_i);
    end
    flush_i = 1'b0; ptw_resp_valid_i = 1'b0; ptw_req_ready_i = 1'b0;
    if (!done) checkOutput("timeout", 64'd0, 64'd1);
  endtask

  task automatic runCheck(input string tag, input logic [PLEN-1:0] addr, input logic [SDID_LEN-1:0] sd,
                          input logic [1:0] acc, input logic [1:0] perm, input logic err,
                          input int delay, input int flush_cycle,
                          input logic exp_allow, input logic exp_fault, input int exp_walks);
    logic allow, fault, stable;
    int walks, lat;
    logic [PLEN-1:0] waddr;
    applyStimulus(addr, sd, acc, perm, err, delay, flush_cycle, allow, fault, walks, waddr, lat, stable);
    checkOutput({tag, ".allow"}, {63'd0, allow}, {63'd0, exp_allow});
    checkOutput({tag, ".fault"}, {63'd0, fault}, {63'd0, exp_fault});
    checkOutput({tag, ".walks"}, 64'(walks), 64'(exp_walks));
    checkOutput({tag, ".latency"}, 64'(lat), (exp_walks != 0) ? 64'(4 + delay) : 64'd1);
    if (exp_walks != 0) begin
      exp_miss++;
      checkOutput({tag, ".walk_addr"}, 64'(waddr), 64'(addr));
      checkOutput({tag, ".walk_stable"}, {63'd0, stable}, 64'd1);
    end else begin
      exp_hit++;
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, ".hit_cnt"}, 64'(hit_cnt_o), 64'(exp_hit));
    checkOutput({tag, ".miss_cnt"}, 64'(miss_cnt_o), 64'(exp_miss));
  endtask

  task automatic pulseFlush();
    @(negedge clk_i);
    flush_i = 1'b1;
    #1 checkOutput("flush.req_ready", {63'd0, req_ready_o}, 64'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  initial begin
    #1;
    checkOutput("reset.req_ready", {63'd0, req_ready_o}, 64'd1);
    checkOutput("reset.resp_valid", {63'd0, resp_valid_o}, 64'd0);
    checkOutput("reset.ptw_valid", {63'd0, ptw_req_valid_o}, 64'd0);
    checkCounters("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    runCheck("cold_read", 56'h1000, 6'd3, 2'b01, 2'b01, 1'b0, 0, 0, 1'b1, 1'b0, 1);
    checkCounters("cold");
    runCheck("hit_write", 56'h1FFC, 6'd3, 2'b10, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    checkCounters("hit");

    runCheck("sdid4_read", 56'h1000, 6'd4, 2'b01, 2'b10, 1'b0, 0, 0, 1'b1, 1'b0, 1);
    runCheck("sdid3_exec", 56'h1234, 6'd3, 2'b11, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0, 0);
    runCheck("sdid4_none", 56'h1000, 6'd4, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 0);

    runCheck("err_first", 56'h5000, 6'd3, 2'b10, 2'b11, 1'b1, 0, 0, 1'b0, 1'b1, 1);
    runCheck("err_repeat", 56'h5000, 6'd3, 2'b10, 2'b11, 1'b1, 0, 0, 1'b0, 1'b1, 1);
    checkCounters("err");

    pulseFlush();
    for (int p = 0; p < 10; p++)
      runCheck("fill", 56'h10000 + 56'(p) * 56'h1000, 6'd1, 2'b01, 2'b11, 1'b0, 0, 0, 1'b1, 1'b0, 1);
    runCheck("repl_page3", 56'h13000, 6'd1, 2'b10, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0, 0);
    runCheck("repl_page9", 56'h19000, 6'd1, 2'b11, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0, 0);
    runCheck("repl_page0", 56'h10000, 6'd1, 2'b01, 2'b11, 1'b0, 0, 0, 1'b1, 1'b0, 1);
    checkCounters("repl");

    runCheck("flush_walk", 56'h30000, 6'd1, 2'b11, 2'b01, 1'b0, 0, 3, 1'b1, 1'b0, 1);
    runCheck("flush_after", 56'h30000, 6'd1, 2'b10, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 1);
    runCheck("flush_earlier", 56'h19000, 6'd1, 2'b01, 2'b11, 1'b0, 0, 0, 1'b1, 1'b0, 1);

    runCheck("ready_stall", 56'h40000, 6'd2, 2'b10, 2'b10, 1'b0, 5, 0, 1'b1, 1'b0, 1);
    checkCounters("stall");

    // Abandon a walk in flight with reset, then feed a stale walk result in IDLE.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_paddr_i = 56'h7000; req_sdid_i = 6'd5; req_access_i = 2'b01;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("midwalk.ptw_valid", {63'd0, ptw_req_valid_o}, 64'd1);
    ptw_req_ready_i = 1'b1;
    @(negedge clk_i);
    ptw_req_ready_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst.resp_valid", {61'd0, resp_valid_o, resp_allow_o, resp_fault_o}, 64'd0);
    checkOutput("rst.ptw", {63'd0, ptw_req_valid_o}, 64'd0);
    checkOutput("rst.ptw_paddr", 64'(ptw_req_paddr_o), 64'd0);
    checkOutput("rst.ptw_sdid", 64'(ptw_req_sdid_o), 64'd0);
    exp_hit = 0; exp_miss = 0;
    checkCounters("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    ptw_resp_valid_i = 1'b1; ptw_resp_perm_i = 2'b11; ptw_resp_error_i = 1'b0;
    @(negedge clk_i);
    ptw_resp_valid_i = 1'b0;
    checkOutput("stale.resp_valid", {63'd0, resp_valid_o}, 64'd0);
    checkOutput("stale.req_ready", {63'd0, req_ready_o}, 64'd1);
    runCheck("post_reset", 56'h7000, 6'd5, 2'b01, 2'b01, 1'b0, 0, 0, 1'b1, 1'b0, 1);
    runCheck("post_reset_old", 56'h1000, 6'd3, 2'b01, 2'b01, 1'b0, 0, 0, 1'b1, 1'b0, 1);
    checkCounters("final");

    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

  // Responses must be single-cycle pulses with allow/fault quiet otherwise.
  logic resp_prev = 1'b0;
  always @(negedge clk_i) begin
    if (resp_valid_o && resp_prev) checkOutput("resp_pulse", 64'd1, 64'd0);
    if (!resp_valid_o && (resp_allow_o || resp_fault_o)) checkOutput("resp_quiet", 64'd1, 64'd0);
    resp_prev <= resp_valid_o;
  end

endmodule
